mem_port_arbiter: RTL and testbench

//   Shares the single 256-bit main-memory port between the instruction cache
//   (port 0) and the data cache (port 1). Each cache sees a private memory

---
 rtl/mem_port_arbiter_if.sv | 23 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Line-sized memory request channel: requester drives enable/write/addr/wr_data,
// responder returns rd_data and a single-cycle ack.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) ();
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              ack;

    modport master (
        output enable, write, addr, wr_data,
        input  rd_data, ack
    );

    modport slave (
        input  enable, write, addr, wr_data,
        output rd_data, ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between icache (p0) and dcache (p1); grant is one cycle after request.
// Requests wait while the other port is served; ack passes straight through; watchdog ends a stuck grant.
module mem_port_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  p0,
    mem_port_arbiter_if.slave  p1,
    mem_port_arbiter_if.master mem,
    output logic               timeout_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               WDOG_ON   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              timeout_nxt;

    logic              sel_en;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              expire;

    // Memory side follows the granted requester combinationally, so an abort
    // or an async reset drops mem.enable without waiting for a clock edge.
    always_comb begin
        sel_en    = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (state == GNT0) begin
            sel_en    = p0.enable;
            sel_write = p0.write;
            sel_addr  = p0.addr;
            sel_wdata = p0.wr_data;
        end else if (state == GNT1) begin
            sel_en    = p1.enable;
            sel_write = p1.write;
            sel_addr  = p1.addr;
            sel_wdata = p1.wr_data;
        end
    end

    assign mem.enable  = sel_en;
    assign mem.write   = sel_write;
    assign mem.addr    = sel_addr;
    assign mem.wr_data = sel_wdata;

    assign p0.ack     = (state == GNT0) && mem.ack;
    assign p1.ack     = (state == GNT1) && mem.ack;
    assign p0.rd_data = (state == GNT0) ? mem.rd_data : '0;
    assign p1.rd_data = (state == GNT1) ? mem.rd_data : '0;

    assign expire = WDOG_ON && (wait_cnt == EXPIRE_AT);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        timeout_nxt    = timeout_o;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (p0.enable && (!p1.enable || last_grant)) begin
                    state_nxt = GNT0;
                end else if (p1.enable) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                // Ack beats both abort and watchdog expiry in the same cycle.
                if (mem.ack) begin
                    state_nxt      = DONE;
                    last_grant_nxt = (state == GNT1);
                end else if (!sel_en) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    state_nxt      = DONE;
                    timeout_nxt    = 1'b1;
                    last_grant_nxt = (state == GNT1);
                end else if (wait_cnt != '1) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
            timeout_o  <= timeout_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic against a transaction-level arbitration model,
// then directed watchdog, abort and async-reset scenarios.
module tb_mem_port_arbiter;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic timeout_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.DATA_W(256), .ADDR_W(32)) p0_if ();
    mem_port_arbiter_if #(.DATA_W(256), .ADDR_W(32)) p1_if ();
    mem_port_arbiter_if #(.DATA_W(256), .ADDR_W(32)) mem_if ();

    mem_port_arbiter #(.DATA_W(256), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .p0        (p0_if.slave),
        .p1        (p1_if.slave),
        .mem       (mem_if.master),
        .timeout_o (timeout_o)
    );

    int checks = 0;
    int errors = 0;

    // requester-side transaction state
    logic         act   [2];
    logic         wr    [2];
    logic [31:0]  ad    [2];
    logic [255:0] wd    [2];
    logic         acked [2];
    int           ndone [2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_ports();
        p0_if.enable  = act[0];
        p0_if.write   = wr[0];
        p0_if.addr    = ad[0];
        p0_if.wr_data = wd[0];
        p1_if.enable  = act[1];
        p1_if.write   = wr[1];
        p1_if.addr    = ad[1];
        p1_if.wr_data = wd[1];
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_men"}, mem_if.enable, 0);
        chk({tag, "_mwr"}, mem_if.write, 0);
        chk({tag, "_maddr"}, mem_if.addr, 0);
        chk({tag, "_mwd"}, mem_if.wr_data, 0);
        chk({tag, "_ack"}, {p1_if.ack, p0_if.ack}, 0);
        chk({tag, "_d0"}, p0_if.rd_data, 0);
        chk({tag, "_d1"}, p1_if.rd_data, 0);
        chk({tag, "_to"}, timeout_o, 0);
    endtask

    initial begin
        logic [1:0]   prev_req;
        logic         prev_men, men, ack;
        logic [255:0] rdat;
        int           last_srv, cur, lat, cnt, gap, first, n;

        // Reset held with both ports requesting: everything must read zero.
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b1; wr[p] = 1'b0; acked[p] = 1'b0; ndone[p] = 0;
            ad[p] = 32'h1000 | (32'(p) << 5);
            wd[p] = '0;
        end
        drive_ports();
        mem_if.ack = 1'b1;
        mem_if.rd_data = rnd256();
        #3;
        chk_all_zero("rst0");
        tick();
        tick();
        chk_all_zero("rst1");
        mem_if.ack = 1'b0;
        rst_i = 1'b1;

        // Arbitration model: a grant goes to the only requester seen in the
        // preceding idle cycle, or to the port not served last when both ask.
        prev_req = 2'b11;
        prev_men = 1'b0;
        last_srv = 1;
        cur = 0; lat = 0; cnt = 0; gap = 99;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acked[p]) begin
                    act[p] = 1'b0;
                    acked[p] = 1'b0;
                end
                if (cyc < 2850 && !act[p] && $urandom_range(0, 2) == 0) begin
                    act[p] = 1'b1;
                    wr[p]  = 1'($urandom_range(0, 1));
                    ad[p]  = ($urandom & 32'hFFFF_FFC0) | (32'(p) << 5);
                    wd[p]  = rnd256();
                end
            end
            drive_ports();
            mem_if.ack = 1'b0;
            #1;
            men  = mem_if.enable;
            ack  = 1'b0;
            rdat = rnd256();
            if (men) begin
                if (!prev_men) begin
                    case (prev_req)
                        2'b01:   cur = 0;
                        2'b10:   cur = 1;
                        2'b11:   cur = (last_srv == 1) ? 0 : 1;
                        default: begin
                            chk("grant_without_request", prev_req, 2'b01);
                            cur = 0;
                        end
                    endcase
                    chk("ack_to_grant_gap_ge2", gap >= 2, 1);
                    lat = $urandom_range(0, 4);
                    cnt = 0;
                end
                chk("mem_addr", mem_if.addr, ad[cur]);
                chk("mem_write", mem_if.write, wr[cur]);
                if (wr[cur]) chk("mem_wdata", mem_if.wr_data, wd[cur]);
                if (cnt == lat) ack = 1'b1;
                else cnt++;
            end else if ($urandom_range(0, 7) == 0) begin
                ack = 1'b1;
            end
            mem_if.ack = ack;
            mem_if.rd_data = rdat;
            #1;
            chk("p0_ack", p0_if.ack, men && ack && cur == 0);
            chk("p1_ack", p1_if.ack, men && ack && cur == 1);
            chk("p0_data", p0_if.rd_data, (men && cur == 0) ? rdat : 256'd0);
            chk("p1_data", p1_if.rd_data, (men && cur == 1) ? rdat : 256'd0);
            chk("timeout_quiet", timeout_o, 0);
            if (men && ack) begin
                acked[cur] = 1'b1;
                last_srv = cur;
                ndone[cur]++;
                gap = 0;
            end else if (!men) begin
                gap++;
            end
            prev_req = {act[1], act[0]};
            prev_men = men;
        end
        mem_if.ack = 1'b0;
        chk("p0_served", ndone[0] > 20, 1);
        chk("p1_served", ndone[1] > 20, 1);
        chk("drained", {act[1], act[0]}, 0);

        // Watchdog: both ask, memory never answers.
        first = (last_srv == 1) ? 0 : 1;
        act[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h0000_0020;
        act[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'h0000_0400;
        drive_ports();
        for (int k = 0; k < 10 && !mem_if.enable; k++) tick();
        chk("to_first_addr", mem_if.addr, ad[first]);
        n = 0;
        while (mem_if.enable && n < 40) begin
            chk("to_no_ack", {p1_if.ack, p0_if.ack}, 0);
            n++;
            tick();
        end
        chk("to_grant_cycles", n, 8);
        chk("to_flag", timeout_o, 1);
        for (int k = 0; k < 10 && !mem_if.enable; k++) tick();
        chk("to_next_addr", mem_if.addr, ad[1 - first]);
        rdat = {8{32'hA5A5_A5A5}};
        mem_if.rd_data = rdat;
        mem_if.ack = 1'b1;
        #1;
        chk("to_next_ack", first == 0 ? p1_if.ack : p0_if.ack, 1);
        chk("to_next_data", first == 0 ? p1_if.rd_data : p0_if.rd_data, rdat);
        tick();
        mem_if.ack = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
        drive_ports();
        tick(); tick(); tick();
        chk("to_sticky", timeout_o, 1);

        // Abort: p0 drops enable mid-grant; arbiter is idle the next cycle.
        act[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h0000_0040; wd[0] = 256'h1234;
        drive_ports();
        for (int k = 0; k < 10 && !mem_if.enable; k++) tick();
        chk("ab_addr", mem_if.addr, 32'h0000_0040);
        chk("ab_wdata", mem_if.wr_data, 256'h1234);
        tick();
        act[0] = 1'b0;
        drive_ports();
        #1;
        chk("ab_men_comb", mem_if.enable, 0);
        tick();
        act[1] = 1'b1; wr[1] = 1'b0; ad[1] = 32'h0000_0400;
        drive_ports();
        tick();
        chk("ab_regrant_en", mem_if.enable, 1);
        chk("ab_regrant_addr", mem_if.addr, 32'h0000_0400);

        // Async reset during GNT1 with both requesting.
        act[0] = 1'b1; ad[0] = 32'h0000_0080; wr[0] = 1'b0;
        drive_ports();
        #2;
        rst_i = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        chk_all_zero("rst_held");
        rst_i = 1'b1;
        tick();
        chk("rst_first_en", mem_if.enable, 1);
        chk("rst_first_addr", mem_if.addr, 32'h0000_0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
